// File: rtl/follower_pkg.sv
// Shared types and constants for the ultrasonic echo ranger.
package follower_pkg;

  localparam int unsigned CNT_W              = 16;
  localparam int unsigned TICKS_PER_US_DEF   = 100;
  localparam int unsigned US_PER_CM_DEF      = 58;
  localparam int unsigned ARM_TIMEOUT_US_DEF = 1000;
  localparam int unsigned ECHO_MAX_US_DEF    = 30000;

  localparam logic [CNT_W-1:0] NO_RANGE = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0] width_us;
    logic [CNT_W-1:0] dist_cm;
    logic             timeout;
  } result_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/echo_ranger.sv
// Ultrasonic echo ranger: times the echo pulse after a trigger fall and
// converts it to microseconds and centimetres by cascaded counters.
module echo_ranger #(
  parameter int unsigned TICKS_PER_US   = follower_pkg::TICKS_PER_US_DEF,
  parameter int unsigned US_PER_CM      = follower_pkg::US_PER_CM_DEF,
  parameter int unsigned ARM_TIMEOUT_US = follower_pkg::ARM_TIMEOUT_US_DEF,
  parameter int unsigned ECHO_MAX_US    = follower_pkg::ECHO_MAX_US_DEF
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        trig,
  input  logic        echo,
  output logic [15:0] width_us,
  output logic [15:0] dist_cm,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);
  import follower_pkg::*;

  state_t           state, state_next;
  result_t          res, res_next;
  logic             trig_r, echo_s, echo_d;
  logic             valid_r, busy_r;
  logic [CNT_W-1:0] presc, us_cnt, cm_sub, dist_acc;
  logic             cnt_clr_c;
  logic             trig_fall_c, echo_rise_c, echo_fall_c;
  logic             presc_wrap_c, cm_wrap_c;
  logic [CNT_W-1:0] us_inc_c, dist_inc_c;

  sync_2ff u_sync (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .d       (echo),
    .q       (echo_s)
  );

  assign trig_fall_c  = trig_r & ~trig;
  assign echo_rise_c  = echo_s & ~echo_d;
  assign echo_fall_c  = ~echo_s & echo_d;
  assign presc_wrap_c = (presc == CNT_W'(TICKS_PER_US - 1));
  assign cm_wrap_c    = presc_wrap_c && (cm_sub == CNT_W'(US_PER_CM - 1));
  // Values including this cycle's tick, so a captured width is not one tick short
  assign us_inc_c     = us_cnt + CNT_W'(presc_wrap_c);
  assign dist_inc_c   = dist_acc + CNT_W'(cm_wrap_c);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state   <= ST_IDLE;
      res     <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      trig_r  <= 1'b0;
      echo_d  <= 1'b0;
    end else begin
      state   <= state_next;
      res     <= res_next;
      valid_r <= (state_next == ST_DONE);
      busy_r  <= (state_next == ST_ARMED) || (state_next == ST_MEASURE);
      trig_r  <= trig;
      echo_d  <= echo_s;
    end
  end

  always_comb begin
    state_next = state;
    res_next   = res;
    cnt_clr_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trig_fall_c) begin
          state_next = ST_ARMED;
          cnt_clr_c  = 1'b1;
        end
      end
      ST_ARMED: begin
        if (echo_rise_c) begin
          state_next = ST_MEASURE;
          cnt_clr_c  = 1'b1;
        end else if (us_cnt == CNT_W'(ARM_TIMEOUT_US)) begin
          state_next = ST_DONE;
          res_next   = '{width_us: '0, dist_cm: NO_RANGE, timeout: 1'b1};
        end
      end
      ST_MEASURE: begin
        if (echo_fall_c) begin
          state_next = ST_DONE;
          res_next   = '{width_us: us_inc_c, dist_cm: dist_inc_c, timeout: 1'b0};
        end else if (us_cnt == CNT_W'(ECHO_MAX_US)) begin
          state_next = ST_DONE;
          res_next   = '{width_us: CNT_W'(ECHO_MAX_US), dist_cm: NO_RANGE, timeout: 1'b1};
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Prescaler -> microseconds -> centimetre sub-count -> distance
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      presc    <= '0;
      us_cnt   <= '0;
      cm_sub   <= '0;
      dist_acc <= '0;
    end else if (cnt_clr_c) begin
      presc    <= '0;
      us_cnt   <= '0;
      cm_sub   <= '0;
      dist_acc <= '0;
    end else if ((state == ST_ARMED) || (state == ST_MEASURE)) begin
      presc  <= presc_wrap_c ? '0 : presc + CNT_W'(1);
      us_cnt <= us_inc_c;
      if ((state == ST_MEASURE) && presc_wrap_c) begin
        cm_sub   <= cm_wrap_c ? '0 : cm_sub + CNT_W'(1);
        dist_acc <= dist_inc_c;
      end
    end
  end

  assign width_us = res.width_us;
  assign dist_cm  = res.dist_cm;
  assign timeout  = res.timeout;
  assign valid    = valid_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_echo_ranger.sv
// Scoreboard bench for echo_ranger; prescaler and echo limit scaled down to keep runs short.
module tb_echo_ranger;

  localparam int unsigned TPU  = 2;
  localparam int unsigned EMAX = 8000;

  typedef struct packed {
    logic [15:0] width_us;
    logic [15:0] dist_cm;
    logic        timeout;
  } exp_t;

  logic        PCLK, PRESETn, trig, echo;
  logic [15:0] width_us, dist_cm;
  logic        valid, timeout, busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  echo_ranger #(
    .TICKS_PER_US   (TPU),
    .US_PER_CM      (58),
    .ARM_TIMEOUT_US (1000),
    .ECHO_MAX_US    (EMAX)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .trig     (trig),
    .echo     (echo),
    .width_us (width_us),
    .dist_cm  (dist_cm),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic fire_trig();
    trig = 1'b1;
    cyc(3);
    trig = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge PCLK);
      n++;
      if (valid) break;
    end
    chk(nm, valid, 1'b1);
  endtask

  task automatic echo_pulse(input int us);
    echo = 1'b1;
    cyc(us * TPU);
    echo = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got width=%0d dist=%0d to=%0b, expected no pulse",
                   width_us, dist_cm, timeout);
        end else begin
          e = sb.pop_front();
          chk("sb_width_us", 32'(width_us), 32'(e.width_us));
          chk("sb_dist_cm",  32'(dist_cm),  32'(e.dist_cm));
          chk("sb_timeout",  32'(timeout),  32'(e.timeout));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    PRESETn = 1'b0;
    trig    = 1'b0;
    echo    = 1'b0;
    cyc(3);
    @(negedge PCLK);
    chk("rst_width", 32'(width_us), 32'd0);
    chk("rst_dist",  32'(dist_cm),  32'd0);
    chk("rst_flags", {29'd0, valid, timeout, busy}, 32'd0);
    cyc(1);
    PRESETn = 1'b1;
    cyc(5);
    chk("idle_busy", 32'(busy), 32'd0);

    // 300 us wait, 5800 us echo -> 100 cm
    fire_trig();
    cyc(3);
    chk("armed_busy", 32'(busy), 32'd1);
    sb.push_back('{16'd5800, 16'd100, 1'b0});
    cyc(300 * TPU);
    echo_pulse(5800);
    wait_valid("valid_5800", 20, n);
    cyc(5);
    chk("hold_dist", 32'(dist_cm), 32'd100);
    chk("idle_busy2", 32'(busy), 32'd0);

    // 57 us echo: one microsecond short of a centimetre
    fire_trig();
    sb.push_back('{16'd57, 16'd0, 1'b0});
    cyc(20);
    echo_pulse(57);
    wait_valid("valid_57", 20, n);
    cyc(5);

    // No echo: arm timeout 1000 us (+<=3 cycles) after trig fall
    fire_trig();
    sb.push_back('{16'd0, 16'hFFFF, 1'b1});
    wait_valid("valid_arm_to", 1000 * TPU + 10, n);
    chk("arm_to_latency", 32'((n >= 1000 * TPU) && (n <= 1000 * TPU + 3)), 32'd1);
    cyc(5);

    // Echo stuck high: echo-max timeout, then echo high at arm is not an edge
    fire_trig();
    sb.push_back('{16'(EMAX), 16'hFFFF, 1'b1});
    cyc(100 * TPU);
    echo = 1'b1;
    wait_valid("valid_echo_max", EMAX * TPU + 20, n);
    chk("echo_max_latency", 32'((n >= EMAX * TPU + 3) && (n <= EMAX * TPU + 6)), 32'd1);
    cyc(5);
    fire_trig();
    sb.push_back('{16'd0, 16'hFFFF, 1'b1});
    wait_valid("valid_high_at_arm", 1000 * TPU + 10, n);
    cyc(5);
    echo = 1'b0;
    cyc(10);

    // Reset 2000 us into an echo discards it; next 1160 us echo -> 20 cm
    fire_trig();
    cyc(100 * TPU);
    echo = 1'b1;
    cyc(2000 * TPU);
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("midrst_width", 32'(width_us), 32'd0);
    chk("midrst_dist",  32'(dist_cm),  32'd0);
    chk("midrst_flags", {29'd0, valid, timeout, busy}, 32'd0);
    echo = 1'b0;
    cyc(3);
    PRESETn = 1'b1;
    cyc(5);
    fire_trig();
    sb.push_back('{16'd1160, 16'd20, 1'b0});
    cyc(100 * TPU);
    echo_pulse(1160);
    wait_valid("valid_after_rst", 20, n);
    cyc(5);

    // Second trig fall mid-measurement is ignored
    fire_trig();
    sb.push_back('{16'd580, 16'd10, 1'b0});
    cyc(50 * TPU);
    echo = 1'b1;
    cyc(200 * TPU);
    fire_trig();
    cyc(2);
    chk("retrig_busy", 32'(busy), 32'd1);
    cyc(380 * TPU - 5);
    echo = 1'b0;
    wait_valid("valid_retrig", 20, n);

    cyc(50);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
